// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin sharing of one multicycle FP divider.
// Optional WAIT watchdog enabled by defining FP_DIV_ARB_TIMEOUT_EN.
module fp_div_arbiter #(
  parameter int DATA_W  = 32,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_op_a,
  input  logic [N_REQ*DATA_W-1:0] req_op_b,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_res,
  output logic                    rsp_err,
  output logic                    div_start,
  output logic [DATA_W-1:0]       div_op_a,
  output logic [DATA_W-1:0]       div_op_b,
  input  logic                    div_done,
  input  logic [DATA_W-1:0]       div_res
);

  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     own_idx;
  logic [PW-1:0]     gnt_idx;
  logic [PW-1:0]     ptr_nxt;
  logic [PW:0]       idx;
  logic              found;
  logic              hs;
  logic              wait_end;
  logic [DATA_W-1:0] res_q;

  if (N_REQ < 2 || TIMEOUT < 1) begin : g_param_chk
    $error("fp_div_arbiter: need N_REQ>=2 and TIMEOUT>=1");
  end

  // first pending requester at or after rr_ptr, wrapping
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N_REQ)) begin
        idx = idx - (PW+1)'(N_REQ);
      end
      if (!found && req_valid[idx[PW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx[PW-1:0];
      end
    end
  end

  assign hs = (state == IDLE) && found && !rst;

  assign ptr_nxt = (gnt_idx == PW'(N_REQ-1)) ?
                   '0 : gnt_idx + PW'(1);

  always_comb begin
    req_ready = '0;
    if (hs) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

`ifdef FP_DIV_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);
  localparam logic [DATA_W-1:0] QNAN =
    DATA_W'(32'h7FC0_0000);

  logic [CW-1:0] wcnt;
  logic          to_hit;
  logic          err_q;

  assign to_hit = (state == WAIT) && !div_done &&
                  (wcnt == CW'(TIMEOUT-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
    end else if (state == WAIT) begin
      wcnt <= wcnt + CW'(1);
    end else begin
      wcnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (hs) begin
      err_q <= 1'b0;
    end else if (to_hit) begin
      err_q <= 1'b1;
    end
  end

  assign wait_end = div_done || to_hit;
  assign rsp_err  = (state == RESP) && err_q;
`else
  assign wait_end = div_done;
  assign rsp_err  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (found) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (wait_end) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      own_idx  <= '0;
      div_op_a <= '0;
      div_op_b <= '0;
      res_q    <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        own_idx  <= gnt_idx;
        rr_ptr   <= ptr_nxt;
        div_op_a <= req_op_a[int'(gnt_idx)*DATA_W +: DATA_W];
        div_op_b <= req_op_b[int'(gnt_idx)*DATA_W +: DATA_W];
      end
      if (state == WAIT && div_done) begin
        res_q <= div_res;
`ifdef FP_DIV_ARB_TIMEOUT_EN
      end else if (to_hit) begin
        res_q <= QNAN;
`endif
      end
    end
  end

  assign div_start = (state == ISSUE);
  assign rsp_res   = (state == RESP) ? res_q : '0;

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) begin
      rsp_valid[own_idx] = 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb_fp_div_arbiter: randomized scoreboard bench with a stub divider.
// Timeout scenario runs only when FP_DIV_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_fp_div_arbiter;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int TO = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  rsp_valid;
  logic [N*DW-1:0] req_op_a;
  logic [N*DW-1:0] req_op_b;
  logic [DW-1:0] rsp_res;
  logic [DW-1:0] div_op_a;
  logic [DW-1:0] div_op_b;
  logic [DW-1:0] div_res;
  logic          rsp_err;
  logic          div_start;
  logic          div_done;

  logic [DW-1:0] opa [N];
  logic [DW-1:0] opb [N];

  typedef struct {
    int            idx;
    logic [DW-1:0] res;
    logic          err;
  } exp_t;
  exp_t sbq[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ptr = 0;
  int grant_cyc = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int force_lat = 0;
  bit hang = 1'b0;
  bit expect_to = 1'b0;
  bit spur = 1'b0;
  bit busy = 1'b0;
  int cnt = 0;
  bit stub_done = 1'b0;
  logic [DW-1:0] stub_res = '0;
  logic [DW-1:0] sa = '0;
  logic [DW-1:0] sb2 = '0;

  logic [DW-1:0] ta [6] = '{32'h40C00000, 32'h3F800000, 32'h41100000,
                            32'h3F800000, 32'h41200000, 32'h41000000};
  logic [DW-1:0] tb [6] = '{32'h40000000, 32'h00000000, 32'h40400000,
                            32'h40000000, 32'h40800000, 32'h40000000};

  fp_div_arbiter #(.DATA_W(DW), .N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
    .rsp_valid(rsp_valid), .rsp_res(rsp_res), .rsp_err(rsp_err),
    .div_start(div_start), .div_op_a(div_op_a), .div_op_b(div_op_b),
    .div_done(div_done), .div_res(div_res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_op_a[i*DW +: DW] = opa[i];
      req_op_b[i*DW +: DW] = opb[i];
    end
  end

  assign div_done = stub_done | spur;
  assign div_res  = stub_res;

  // known IEEE quotients for the table, a keyed hash otherwise
  function automatic logic [DW-1:0] fref(logic [DW-1:0] a, logic [DW-1:0] b);
    case ({a, b})
      {32'h40C00000, 32'h40000000}: return 32'h40400000;
      {32'h3F800000, 32'h00000000}: return 32'h7F800000;
      {32'h41100000, 32'h40400000}: return 32'h40400000;
      {32'h3F800000, 32'h40000000}: return 32'h3F000000;
      {32'h41200000, 32'h40800000}: return 32'h40200000;
      {32'h41000000, 32'h40000000}: return 32'h40800000;
      default: return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A5A5A;
    endcase
  endfunction

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int pick(logic [N-1:0] pat, int p);
    for (int k = 0; k < N; k++) begin
      if (pat[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // stub divider: latency counted in negedges after the start pulse
  always @(negedge clk) begin
    if (rst) begin
      busy = 1'b0;
      stub_done = 1'b0;
    end else begin
      stub_done = 1'b0;
      stub_res = $urandom;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          busy = 1'b0;
          stub_done = 1'b1;
          stub_res = fref(sa, sb2);
          done_cyc = cyc;
          if (!hang)
            check("op_stable", {div_op_a, div_op_b}, {sa, sb2});
        end
      end
      if (div_start) begin
        check("start_busy", 64'(busy), 64'd0);
        check("start_lat", 64'(cyc), 64'(grant_cyc + 1));
        busy = 1'b1;
        start_cyc = cyc;
        sa = div_op_a;
        sb2 = div_op_b;
        if (hang) cnt = TO + 3;
        else if (force_lat > 0) cnt = force_lat;
        else cnt = $urandom_range(1, 6);
      end
    end
  end

  // response monitor
  always @(negedge clk) begin
    if (!rst && rsp_valid != '0) begin
      if (sbq.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("rsp_owner", 64'(rsp_valid), 64'(onehot(e.idx)));
        check("rsp_res", 64'(rsp_res), 64'(e.res));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        if (e.err)
          check("rsp_to_lat", 64'(cyc), 64'(start_cyc + TO + 1));
        else
          check("rsp_lat", 64'(cyc), 64'(done_cyc + 1));
      end
    end
  end

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_ops(input int i);
    int k;
    if ($urandom_range(0, 1) == 1) begin
      k = $urandom_range(0, 5);
      opa[i] = ta[k];
      opb[i] = tb[k];
    end else begin
      opa[i] = $urandom;
      opb[i] = $urandom;
    end
  endtask

  task automatic do_round(input logic [N-1:0] pat, input bit drop,
                          input bit rnd);
    int w;
    bit got;
    exp_t e;
    nclk();
    if (rnd) begin
      for (int i = 0; i < N; i++) if (pat[i]) rand_ops(i);
    end
    req_valid = pat;
    w = pick(pat, ptr);
    e.idx = w;
    e.res = expect_to ? 32'h7FC00000 : fref(opa[w], opb[w]);
    e.err = expect_to;
    sbq.push_back(e);
    got = 1'b0;
    for (int t = 0; t < 400; t++) begin
      #1;
      if (req_ready != '0) begin
        got = 1'b1;
        break;
      end
      nclk();
    end
    check("grant_seen", 64'(got), 64'd1);
    check("grant", 64'(req_ready), 64'(onehot(w)));
    grant_cyc = cyc;
    ptr = (w + 1) % N;
    nclk();
    if (drop) req_valid[w] = 1'b0;
    opa[w] = $urandom;
    opb[w] = $urandom;
  endtask

  task automatic drain();
    for (int t = 0; t < 400; t++) begin
      if (sbq.size() == 0) break;
      nclk();
    end
    check("drain", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    repeat (3) nclk();
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_res", 64'(rsp_res), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_start", 64'(div_start), 64'd0);
    check("rst_op", {div_op_a, div_op_b}, 64'd0);
    req_valid = '0;
    rst = 1'b0;

    opa[0] = 32'h40C00000;
    opb[0] = 32'h40000000;
    do_round(4'b0001, 1'b1, 1'b0);

    force_lat = 20;
    do_round(4'b0001, 1'b1, 1'b1);
    repeat (5) nclk();
    #1 rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    check("mid_rst_rsp", {32'(rsp_valid), rsp_res}, 64'd0);
    check("mid_rst_err", 64'(rsp_err), 64'd0);
    check("mid_rst_start", 64'(div_start), 64'd0);
    check("mid_rst_op", {div_op_a, div_op_b}, 64'd0);
    sbq.delete();
    ptr = 0;
    nclk();
    rst = 1'b0;
    force_lat = 0;

    for (int r = 0; r < 5; r++) do_round(4'b1111, r == 4, 1'b1);
    do_round(4'b0010, 1'b1, 1'b1);
    drain();

    force_lat = 1;
    opa[2] = 32'h3F800000;
    opb[2] = 32'h00000000;
    do_round(4'b0100, 1'b1, 1'b0);
    drain();
    force_lat = 0;

    nclk();
    spur = 1'b1;
    nclk();
    spur = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nclk();
      check("spur_no_rsp", 64'(rsp_valid), 64'd0);
    end
    do_round(4'b1000, 1'b1, 1'b1);

    for (int r = 0; r < 40; r++) begin
      do_round(N'($urandom_range(1, (1 << N) - 1)),
               1'($urandom_range(0, 1)), 1'b1);
    end
    req_valid = '0;
    drain();

`ifdef FP_DIV_ARB_TIMEOUT_EN
    hang = 1'b1;
    expect_to = 1'b1;
    do_round(4'b0001, 1'b1, 1'b1);
    expect_to = 1'b0;
    drain();
    repeat (10) nclk();
    hang = 1'b0;
    do_round(4'b0010, 1'b1, 1'b1);
    drain();
`endif

    repeat (5) nclk();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
